// File: rtl/fsmc_pkg.sv
// Shared FSMC definitions: bus widths, default phase lengths and the initiator state encoding.
package fsmc_pkg;

  localparam int FSMC_ADDR_W  = 18;
  localparam int FSMC_DATA_W  = 16;
  localparam int FSMC_ADDSET  = 5;
  localparam int FSMC_ADDHLD  = 4;
  localparam int FSMC_DATAST  = 8;
  localparam int FSMC_BUSTURN = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_AHOLD = 3'd2,
    ST_DATA  = 3'd3,
    ST_TURN  = 3'd4
  } fsmc_state_e;

  function automatic int fsmc_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b; else m = m;
    if (c > m) m = c; else m = m;
    if (d > m) m = d; else m = m;
    return m;
  endfunction

endpackage

// File: rtl/fsmc_phase_cnt.sv
// Loadable down-counter that times one bus phase; zero_o marks the last cycle of the phase.
module fsmc_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load on phase entry, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fsmc_master.sv
// FSMC initiator: turns single-beat requests into multiplexed AD bus cycles.
// Every pad output is registered and decoded from the next state.
module fsmc_master
  import fsmc_pkg::*;
#(
  parameter int ADDR_W  = FSMC_ADDR_W,
  parameter int DATA_W  = FSMC_DATA_W,
  parameter int ADDSET  = FSMC_ADDSET,
  parameter int ADDHLD  = FSMC_ADDHLD,
  parameter int DATAST  = FSMC_DATAST,
  parameter int BUSTURN = FSMC_BUSTURN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o,
  output logic              nadv_o,
  output logic              nwe_o,
  output logic              noe_o,
  output logic [ADDR_W-1:0] ad_out_o,
  output logic              ad_oe_o,
  input  logic [ADDR_W-1:0] ad_in_i
);

  localparam int MAX_PH = fsmc_max4(ADDSET, ADDHLD, DATAST, BUSTURN);
  localparam int CNT_W  = $clog2(MAX_PH) + 1;

  if (ADDSET < 1 || ADDHLD < 1 || DATAST < 1 || BUSTURN < 1) begin : g_bad_phase
    $error("fsmc_master: every phase length must be at least 1");
  end

  fsmc_state_e       state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              nadv_q, nadv_d, nwe_q, nwe_d, noe_q, noe_d;
  logic              ad_oe_q, ad_oe_d;
  logic [ADDR_W-1:0] ad_out_q, ad_out_d;
  logic              rsp_valid_q, rsp_valid_d, busy_q, busy_d, req_ready_q, req_ready_d;
  logic              accept_s, zero_s, load_s;
  logic [CNT_W-1:0]  load_val_s;
  logic              unused_s;

  assign accept_s = req_valid_i && req_ready_q;
  assign unused_s = ^ad_in_i[ADDR_W-1:DATA_W];

  fsmc_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .zero_o     (zero_s)
  );

  // next state, request latching, read capture and registered pad decode
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    load_s      = 1'b0;
    load_val_s  = '0;
    rsp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_ADDR;
          write_d    = req_write_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          load_s     = 1'b1;
          load_val_s = CNT_W'(ADDSET - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (zero_s) begin
          state_d    = ST_AHOLD;
          load_s     = 1'b1;
          load_val_s = CNT_W'(ADDHLD - 1);
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_AHOLD: begin
        if (zero_s) begin
          state_d    = ST_DATA;
          load_s     = 1'b1;
          load_val_s = CNT_W'(DATAST - 1);
        end else begin
          state_d = ST_AHOLD;
        end
      end
      ST_DATA: begin
        if (zero_s) begin
          state_d    = ST_TURN;
          load_s     = 1'b1;
          load_val_s = CNT_W'(BUSTURN - 1);
          if (!write_q) rdata_d = ad_in_i[DATA_W-1:0];
          else          rdata_d = rdata_q;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_TURN: begin
        if (zero_s) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_TURN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    nadv_d   = 1'b1;
    nwe_d    = 1'b1;
    noe_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    case (state_d)
      ST_ADDR: begin
        nadv_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      ST_AHOLD: begin
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        nwe_d    = !write_d;
      end
      ST_DATA: begin
        if (write_d) begin
          nwe_d    = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = ADDR_W'(wdata_d);
        end else begin
          noe_d = 1'b0;
        end
      end
      ST_TURN: begin
        if (write_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = ADDR_W'(wdata_d);
        end else begin
          ad_oe_d = 1'b0;
        end
      end
      default: ad_oe_d = 1'b0;
    endcase
    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  // state, latched request and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      nadv_q      <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      nadv_q      <= nadv_d;
      nwe_q       <= nwe_d;
      noe_q       <= noe_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign busy_o      = busy_q;
  assign nadv_o      = nadv_q;
  assign nwe_o       = nwe_q;
  assign noe_o       = noe_q;
  assign ad_oe_o     = ad_oe_q;
  assign ad_out_o    = ad_out_q;

endmodule
